// File: rtl/tdm_demux_1_to_4_if.sv
// Purpose : bundles the serial TDM input, channel select and demux results into one port.
// Latency : none (wires only).
// Backpressure: none; the link is paced by en, there is no ready path back to the sender.
// Ports (master = stimulus side, slave = demux side):
//   en, din, sync, ch_sel            -> slave inputs (slot enable, serial bit, frame strobe, y select)
//   frame_out, frame_valid, y,
//   locked, sync_err                 -> slave outputs (parallel frame, strobe, selected bit, status)
interface tdm_demux_1_to_4_if #(
  parameter int ERR_W = 8
);
  logic             en;
  logic             din;
  logic             sync;
  logic [1:0]       ch_sel;
  logic [3:0]       frame_out;
  logic             frame_valid;
  logic             y;
  logic             locked;
  logic [ERR_W-1:0] sync_err;

  modport master (
    output en, din, sync, ch_sel,
    input  frame_out, frame_valid, y, locked, sync_err
  );

  modport slave (
    input  en, din, sync, ch_sel,
    output frame_out, frame_valid, y, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux_1_to_4.sv
// Purpose : 1:4 TDM demux; rebuilds 4-slot frames from a serial stream aligned by a slot-0 sync strobe.
// Latency : frame_out/frame_valid one cycle after the slot-3 sample; y is combinational from frame_out.
// Backpressure: en=0 freezes slot position and all state; no ready is offered upstream.
// Ports:
//   clk, rst (sync, active-high)  -- plain scalars
//   bus (tdm_demux_1_to_4_if.slave) -- en, din, sync, ch_sel in; frame_out, frame_valid, y, locked, sync_err out
module tdm_demux_1_to_4 #(
  parameter int ERR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  tdm_demux_1_to_4_if.slave    bus
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_n;
  logic [1:0]       slot_q, slot_n;
  logic [2:0]       shift_q, shift_n;
  logic [3:0]       frame_q, frame_n;
  logic             valid_q, valid_n;
  logic [ERR_W-1:0] err_q, err_n;
  logic             err_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= '0;
      shift_q <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_n;
      slot_q  <= slot_n;
      shift_q <= shift_n;
      frame_q <= frame_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    slot_n  = slot_q;
    shift_n = shift_q;
    frame_n = frame_q;
    valid_n = 1'b0;        // strobe only on the cycle after a frame completes
    err_inc = 1'b0;

    if (bus.en) begin
      unique case (state_q)
        HUNT: begin
          if (bus.sync) begin
            shift_n[0] = bus.din;
            slot_n     = 2'd1;
            state_n    = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.sync) begin
            // A sync anywhere but slot 0 abandons the partial frame and
            // restarts alignment from this cycle.
            err_inc    = (slot_q != 2'd0);
            shift_n[0] = bus.din;
            slot_n     = 2'd1;
          end else if (slot_q == 2'd0) begin
            // Expected sync missing: alignment lost, sample discarded.
            err_inc = 1'b1;
            state_n = HUNT;
          end else if (slot_q == 2'd3) begin
            frame_n = {bus.din, shift_q};
            valid_n = 1'b1;
            slot_n  = 2'd0;
          end else begin
            shift_n[slot_q] = bus.din;
            slot_n          = slot_q + 2'd1;
          end
        end
        default: state_n = HUNT;
      endcase
    end

    err_n = err_q;
    if (err_inc && (err_q != {ERR_W{1'b1}})) begin
      err_n = err_q + 1'b1;  // saturate, never wrap
    end
  end

  assign bus.frame_out   = frame_q;
  assign bus.frame_valid = valid_q;
  assign bus.y           = frame_q[bus.ch_sel];
  assign bus.locked      = (state_q == LOCKED);
  assign bus.sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
module tb_tdm_demux_1_to_4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       sync = 1'b0;
  logic [1:0] ch_sel = 2'd0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tdm_demux_1_to_4_if #(.ERR_W(8)) bus8 ();
  tdm_demux_1_to_4_if #(.ERR_W(2)) bus2 ();

  assign bus8.en = en;
  assign bus8.din = din;
  assign bus8.sync = sync;
  assign bus8.ch_sel = ch_sel;
  assign bus2.en = en;
  assign bus2.din = din;
  assign bus2.sync = sync;
  assign bus2.ch_sel = ch_sel;

  tdm_demux_1_to_4 #(.ERR_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  tdm_demux_1_to_4 #(.ERR_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Inputs seen by the DUT at each rising edge.
  logic c_rst, c_en, c_din, c_sync;
  initial forever begin
    @(posedge clk);
    c_rst  = rst;
    c_en   = en;
    c_din  = din;
    c_sync = sync;
  end

  // Model: a queue of bits gathered since the last accepted sync.
  logic q[$];
  bit   m_locked = 0;
  bit   m_fv = 0;
  int   m_err = 0;
  logic [3:0] m_frame = 4'h0;

  initial forever begin
    @(negedge clk);
    if (c_rst) begin
      q.delete();
      m_locked = 0;
      m_fv = 0;
      m_err = 0;
      m_frame = 4'h0;
    end else begin
      m_fv = 0;
      if (c_en) begin
        if (c_sync) begin
          if (m_locked && q.size() != 0) m_err++;
          q.delete();
          q.push_back(c_din);
          m_locked = 1;
        end else if (m_locked) begin
          if (q.size() == 0) begin
            m_err++;
            m_locked = 0;
          end else begin
            q.push_back(c_din);
            if (q.size() == 4) begin
              m_frame = {q[3], q[2], q[1], q[0]};
              m_fv = 1;
              q.delete();
            end
          end
        end
      end
    end
    chk("frame_out8", int'(bus8.frame_out), int'(m_frame));
    chk("frame_valid8", int'(bus8.frame_valid), int'(m_fv));
    chk("y8", int'(bus8.y), int'(m_frame[ch_sel]));
    chk("locked8", int'(bus8.locked), int'(m_locked));
    chk("sync_err8", int'(bus8.sync_err), (m_err > 255) ? 255 : m_err);
    chk("frame_out2", int'(bus2.frame_out), int'(m_frame));
    chk("frame_valid2", int'(bus2.frame_valid), int'(m_fv));
    chk("sync_err2", int'(bus2.sync_err), (m_err > 3) ? 3 : m_err);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic e, input logic d, input logic s);
    rst = r;
    en = e;
    din = d;
    sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] f);
    drive(1'b0, 1'b1, f[0], 1'b1);
    for (int i = 1; i < 4; i++) drive(1'b0, 1'b1, f[i], 1'b0);
  endtask

  initial begin
    int p;
    logic e, s;

    // Reset then idle.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_frame_out", int'(bus8.frame_out), 0);
    chk("rst_frame_valid", int'(bus8.frame_valid), 0);
    chk("rst_locked", int'(bus8.locked), 0);
    chk("rst_sync_err", int'(bus8.sync_err), 0);
    chk("rst_y", int'(bus8.y), 0);

    // Two back-to-back frames.
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    chk("locked_after_sync", int'(bus8.locked), 1);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("no_valid_midframe", int'(bus8.frame_valid), 0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("frame_A", int'(bus8.frame_out), 4'hA);
    chk("valid_A", int'(bus8.frame_valid), 1);
    send_frame(4'h6);
    chk("frame_6", int'(bus8.frame_out), 4'h6);
    chk("valid_6", int'(bus8.frame_valid), 1);
    chk("err_after_good", int'(bus8.sync_err), 0);

    // Frame D with a 3-cycle en gap between slots 1 and 2.
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("gap_no_valid", int'(bus8.frame_valid), 0);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("frame_D", int'(bus8.frame_out), 4'hD);
    chk("err_after_gap", int'(bus8.sync_err), 0);

    // Early sync at slot 2, then 0011 from that sync.
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    chk("early_sync_err", int'(bus8.sync_err), 1);
    chk("early_sync_locked", int'(bus8.locked), 1);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("broken_no_valid", int'(bus8.frame_valid), 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("frame_3", int'(bus8.frame_out), 4'h3);
    chk("valid_3", int'(bus8.frame_valid), 1);

    // Missing sync at slot 0, data ignored, then relock with F.
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("missing_sync_err", int'(bus8.sync_err), 2);
    chk("missing_sync_unlock", int'(bus8.locked), 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("hunt_holds_frame", int'(bus8.frame_out), 4'h3);
    chk("hunt_no_err", int'(bus8.sync_err), 2);
    send_frame(4'hF);
    chk("frame_F", int'(bus8.frame_out), 4'hF);

    // Channel sweep on frame A.
    send_frame(4'hA);
    for (int k = 0; k < 4; k++) begin
      ch_sel = 2'(k);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("y_sweep", int'(bus8.y), k % 2);
    end

    // Repeated syncs: first is a normal slot 0, the next five are early.
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b1, 1'b1);
    chk("err8_after_5", int'(bus8.sync_err), 7);
    chk("err2_saturated", int'(bus2.sync_err), 3);

    // Reset mid-frame.
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("mid_rst_frame", int'(bus8.frame_out), 0);
    chk("mid_rst_locked", int'(bus8.locked), 0);
    chk("mid_rst_err8", int'(bus8.sync_err), 0);
    chk("mid_rst_err2", int'(bus2.sync_err), 0);
    chk("mid_rst_y", int'(bus8.y), 0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("post_rst_hunt", int'(bus8.locked), 0);

    // Randomized traffic: mostly well-formed frames with stray/missing syncs and gaps.
    p = 0;
    for (int n = 0; n < 3000; n++) begin
      ch_sel = 2'($urandom_range(0, 3));
      e = ($urandom_range(0, 3) != 0);
      if (p == 0) s = ($urandom_range(0, 9) != 0);
      else        s = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 599) == 0) begin
        drive(1'b1, e, 1'($urandom_range(0, 1)), s);
        p = 0;
      end else begin
        drive(1'b0, e, 1'($urandom_range(0, 1)), s);
        if (e) p = (p + 1) % 4;
      end
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
